// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Single-port memory controller serving two requesters: instruction fetch (IF)
// and load/store (MEM). Both share one byte-wide synchronous RAM. 32-bit
// little-endian words are split into byte beats for stores and reassembled
// from byte beats for loads and fetches. MEM has priority over IF.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   if_req/if_addr  fetch request (held until if_done) and byte address
//   flush           branch redirect; aborts an in-flight fetch
//   mem_req/mem_we  load/store request (held until mem_done), 1 = store
//   mem_len         00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   mem_addr        load/store byte address
//   mem_wdata       store data, byte k goes to addr+k
//   ram_din         RAM read data, valid one cycle after its address
//   ram_dout/ram_a  RAM write data and byte address
//   ram_wr          RAM write enable
//   if_done/if_inst fetch completion pulse and fetched word (held)
//   mem_done        load/store completion pulse
//   mem_rdata       zero-extended load data (held until the next load)
//   if_busy         if_req & ~if_done, IF stall request
//   mem_busy        mem_req & ~mem_done, MEM stall request
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int RAM_AW = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              flush,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_busy,
    output logic              mem_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        beat;       // beat index of the current cycle (cycle = beat+1)
    logic [2:0]        nbeats;     // number of byte beats of the active request
    logic [31:0]       base;       // latched byte address
    logic [DATA_W-1:0] wdata;      // latched store data
    logic [DATA_W-1:0] rd_buf;     // bytes captured so far for a read

    logic [2:0]        mem_n;
    logic [2:0]        beat_nxt;
    logic [31:0]       nxt_addr;
    logic [7:0]        nxt_byte;
    logic [DATA_W-1:0] rd_word;
    logic              can_accept;
    logic              accept_mem;
    logic              accept_if;
    logic              unused_hi;

    always_comb begin
        case (mem_len)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    // A done flag still high means the requester has not yet dropped its
    // request, so IDLE waits one cycle before accepting anything.
    assign can_accept = (state == IDLE) && !if_done && !mem_done;
    assign accept_mem = can_accept && mem_req;
    assign accept_if  = can_accept && !mem_req && if_req && !flush;

    assign beat_nxt = beat + 3'd1;

    // Address is formed at full width; only the low RAM_AW bits reach the
    // RAM, so running off the top wraps silently.
    assign nxt_addr  = base + {29'd0, beat_nxt};
    assign unused_hi = ^nxt_addr[31:RAM_AW];

    always_comb begin
        case (beat_nxt)
            3'd1:    nxt_byte = wdata[15:8];
            3'd2:    nxt_byte = wdata[23:16];
            3'd3:    nxt_byte = wdata[31:24];
            default: nxt_byte = wdata[7:0];
        endcase
    end

    // ram_din in cycle beat+1 carries the byte addressed one cycle earlier,
    // i.e. byte (beat-1); merge it into the partially assembled word.
    always_comb begin
        rd_word = rd_buf;
        case (beat)
            3'd1:    rd_word[7:0]   = ram_din;
            3'd2:    rd_word[15:8]  = ram_din;
            3'd3:    rd_word[23:16] = ram_din;
            3'd4:    rd_word[31:24] = ram_din;
            default: rd_word = rd_buf;
        endcase
    end

    assign if_busy  = if_req & ~if_done;
    assign mem_busy = mem_req & ~mem_done;

    // Request latch and read assembly buffer; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept_mem) begin
            base   <= mem_addr;
            wdata  <= mem_wdata;
            nbeats <= mem_n;
            rd_buf <= '0;
        end else if (accept_if) begin
            base   <= if_addr;
            nbeats <= 3'd4;
            rd_buf <= '0;
        end else if ((state == IF_RD || state == MEM_RD) && beat != 3'd0) begin
            rd_buf <= rd_word;
        end
    end

    // Control FSM with registered RAM strobes and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 3'd0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= 3'd0;
                    if (accept_mem) begin
                        ram_a <= mem_addr[RAM_AW-1:0];
                        if (mem_we) begin
                            state    <= MEM_WR;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state <= MEM_RD;
                        end
                    end else if (accept_if) begin
                        ram_a <= if_addr[RAM_AW-1:0];
                        state <= IF_RD;
                    end
                end

                IF_RD, MEM_RD: begin
                    if (state == IF_RD && flush) begin
                        // Redirect: drop the fetch and any partial bytes.
                        state <= IDLE;
                    end else begin
                        beat <= beat_nxt;
                        if (beat_nxt < nbeats) begin
                            ram_a <= nxt_addr[RAM_AW-1:0];
                        end
                        // beat == nbeats: last byte is on ram_din now.
                        if (beat == nbeats) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                if_inst <= rd_word;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= rd_word;
                                mem_done  <= 1'b1;
                            end
                        end
                    end
                end

                MEM_WR: begin
                    if (beat_nxt < nbeats) begin
                        beat     <= beat_nxt;
                        ram_a    <= nxt_addr[RAM_AW-1:0];
                        ram_dout <= nxt_byte;
                    end else begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller and the responder side of the pipeline's memory-request interface.
- Arbitrates instruction fetches from IF and loads/stores from MEM onto one byte-wide synchronous RAM.
- Assembles or splits 32-bit little-endian data over 1/2/4 byte beats.
- Returns per-requester busy flags; ctrl turns these into the stall[5:0] vector consumed by the pipeline registers.

Parameters:
- RAM_AW, 17: RAM address width; ram_a carries the low RAM_AW bits of the byte address.
- DATA_W, 32: request data width. Fixed at 32; not meant to be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1).
- if_req  in  1  IF fetch request; held high until if_done.
- if_addr  in  32  fetch byte address.
- flush  in  1  branch redirect; aborts an in-flight fetch.
- mem_req  in  1  MEM load/store request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes (10 is treated as 4).
- mem_addr  in  32  load/store byte address.
- mem_wdata  in  32  store data; byte k goes to addr+k.
- ram_din  in  8  RAM read data; valid one cycle after its address.
- ram_dout  out  8  RAM write data.
- ram_a  out  RAM_AW  RAM byte address.
- ram_wr  out  1  RAM write enable.
- if_done  out  1  one-cycle pulse; if_inst valid in the same cycle.
- if_inst  out  32  fetched word; holds its value until the next fetch completes.
- mem_done  out  1  one-cycle pulse; the load or store has completed.
- mem_rdata  out  32  load data, zero-extended; holds until the next load completes.
- if_busy  out  1  combinational: if_req & ~if_done (IF stall request).
- mem_busy  out  1  combinational: mem_req & ~mem_done (MEM stall request).

Behaviour:
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- Beat count n: 4 for a fetch; 1, 2 or 4 for MEM according to mem_len.
- Reset values: state IDLE, beat counter 0, ram_a 0, ram_dout 0, ram_wr 0, if_done 0, mem_done 0, if_inst 0, mem_rdata 0.

Request acceptance (IDLE only; the accept edge is cycle 0):
- If if_done or mem_done is high, nothing is accepted. This one-cycle cool-down stops a completed request being accepted again.
- Otherwise mem_req has priority over if_req.
- if_req with flush high is not accepted.
- Addresses and data are latched at the accept edge; later changes on the inputs are ignored.

Read (IF_RD / MEM_RD):
- Cycles 1..n: ram_a = base+k for k = 0..n-1; ram_wr = 0.
- Byte k is captured from ram_din in cycle k+2 into bits [8k+7:8k].
- if_done or mem_done goes high in cycle n+2; the data output updates in the same cycle.
- State returns to IDLE at the end of cycle n+1.
- Word read: done in cycle 6. Byte read: done in cycle 3.
- Unused upper bytes of mem_rdata are 0.

Write (MEM_WR):
- Cycles 1..n: ram_wr = 1, ram_a = base+k, ram_dout = mem_wdata[8k+7:8k].
- mem_done in cycle n+1; ram_wr returns to 0 in that cycle.
- Word store: done in cycle 5.

Address arithmetic:
- base+k is computed at 32 bits, then truncated to RAM_AW bits.
- Wrap at the top of RAM is silent.

Flush:
- Sampled every cycle.
- In IF_RD: next state IDLE, no if_done, if_inst unchanged, partial bytes discarded.
- In the MEM states: ignored.
- In IDLE: blocks if acceptance only.

Other rules:
- A pending if_req while a MEM operation is running waits; if_busy stays high throughout.
- A mem_req arriving during IF_RD waits until the fetch completes. It is accepted in the first IDLE cycle with both done flags low.
- rst in any state returns the block to reset values at that edge and drops ram_wr the next cycle. No done pulse is produced for the aborted operation.

Test Plan:
- Word fetch: if_addr=0x100, RAM holds 13 05 00 00 at 0x100–0x103; hold if_req. Expect ram_a 0x100..0x103 in cycles 1–4, if_done pulse in cycle 6, if_inst=0x00000513, if_busy low in cycle 6.
- Byte load: mem_len=00, mem_addr=0x205, RAM[0x205]=0xF0. Expect mem_done in cycle 3, mem_rdata=0x000000F0.
- Word store: mem_we=1, mem_len=11, mem_addr=0x40, mem_wdata=0xDEADBEEF. Expect ram_wr high cycles 1–4 with EF, BE, AD, DE at 0x40..0x43, and mem_done in cycle 5. A following word read of 0x40 returns 0xDEADBEEF.
- Simultaneous if_req and mem_req (halfword load at 0x10) in IDLE: MEM is served first with mem_done in cycle 4. The fetch is accepted in cycle 5 (first IDLE cycle with both done flags low) with if_done in cycle 11; if_busy stays high throughout.
- Flush asserted in cycle 3 of a fetch: no if_done, if_inst unchanged, state IDLE next cycle. A new if_req with flush low starts a fresh 4-beat fetch.
- rst asserted in cycle 2 of a word store: ram_wr 0 from cycle 3, no mem_done, all outputs at reset values, and the next request is served normally.
